// File: rtl/wb_dec_1m_3s.sv
`default_nettype none
// =============================================================================
// wb_dec_1m_3s : Wishbone pipelined 1-master / 3-slave address decoder, in-order
//                response tracking; optional timeout under WB_DEC_TIMEOUT_EN.
// Revision     : 1.0 - initial release
// =============================================================================
module wb_dec_1m_3s #(
   parameter logic [31:0] S0_BASE   = 32'h0000_0000,
   parameter logic [31:0] S0_MASK   = 32'hF000_0000,
   parameter logic [31:0] S1_BASE   = 32'h1000_0000,
   parameter logic [31:0] S1_MASK   = 32'hF000_0000,
   parameter logic [31:0] S2_BASE   = 32'h2000_0000,
   parameter logic [31:0] S2_MASK   = 32'hF000_0000,
   parameter int          MAX_OUTST = 4,
   parameter int          TIMEOUT   = 255
) (
   input  logic        CLK,
   input  logic        RST_ASYNC_N,
   input  logic [31:0] WB_SL0_ADR_IN,
   input  logic        WB_SL0_CYC_IN,
   input  logic        WB_SL0_STB_IN,
   input  logic        WB_SL0_WE_IN,
   input  logic [3:0]  WB_SL0_SEL_IN,
   input  logic [2:0]  WB_SL0_CTI_IN,
   input  logic [1:0]  WB_SL0_BTE_IN,
   input  logic [31:0] WB_SL0_WR_DAT_IN,
   output logic        WB_SL0_STALL_OUT,
   output logic        WB_SL0_ACK_OUT,
   output logic        WB_SL0_ERR_OUT,
   output logic [31:0] WB_SL0_RD_DAT_OUT,
   output logic [31:0] WB_M0_ADR_OUT,
   output logic        WB_M0_WE_OUT,
   output logic [3:0]  WB_M0_SEL_OUT,
   output logic [2:0]  WB_M0_CTI_OUT,
   output logic [1:0]  WB_M0_BTE_OUT,
   output logic [31:0] WB_M0_WR_DAT_OUT,
   output logic        WB_M0_CYC_OUT,
   output logic        WB_M0_STB_OUT,
   input  logic        WB_M0_STALL_IN,
   input  logic        WB_M0_ACK_IN,
   input  logic        WB_M0_ERR_IN,
   input  logic [31:0] WB_M0_RD_DAT_IN,
   output logic [31:0] WB_M1_ADR_OUT,
   output logic        WB_M1_WE_OUT,
   output logic [3:0]  WB_M1_SEL_OUT,
   output logic [2:0]  WB_M1_CTI_OUT,
   output logic [1:0]  WB_M1_BTE_OUT,
   output logic [31:0] WB_M1_WR_DAT_OUT,
   output logic        WB_M1_CYC_OUT,
   output logic        WB_M1_STB_OUT,
   input  logic        WB_M1_STALL_IN,
   input  logic        WB_M1_ACK_IN,
   input  logic        WB_M1_ERR_IN,
   input  logic [31:0] WB_M1_RD_DAT_IN,
   output logic [31:0] WB_M2_ADR_OUT,
   output logic        WB_M2_WE_OUT,
   output logic [3:0]  WB_M2_SEL_OUT,
   output logic [2:0]  WB_M2_CTI_OUT,
   output logic [1:0]  WB_M2_BTE_OUT,
   output logic [31:0] WB_M2_WR_DAT_OUT,
   output logic        WB_M2_CYC_OUT,
   output logic        WB_M2_STB_OUT,
   input  logic        WB_M2_STALL_IN,
   input  logic        WB_M2_ACK_IN,
   input  logic        WB_M2_ERR_IN,
   input  logic [31:0] WB_M2_RD_DAT_IN
);

   typedef enum logic [2:0] {
      SEL_NONE = 3'd0,
      SEL_S0   = 3'd1,
      SEL_S1   = 3'd2,
      SEL_S2   = 3'd3,
      SEL_UNM  = 3'd4
   } sel_t;

   localparam logic [3:0] c_MAX_OUTST = 4'(MAX_OUTST);

   sel_t        r_sel;
   sel_t        w_dec;
   logic [3:0]  r_cnt;
   logic        r_unm_err;
   logic        w_busy, w_full, w_drain, w_tgt_stall, w_stall, w_acc;
   logic        w_rsp_ack, w_rsp_err, w_ack, w_err, w_rsp, w_tmo_hit, w_live;
   logic [31:0] w_rsp_dat;
   logic [2:0]  w_dec_oh, w_sel_oh;

   always_comb begin
      if ((WB_SL0_ADR_IN & S0_MASK) == S0_BASE)      w_dec = SEL_S0;
      else if ((WB_SL0_ADR_IN & S1_MASK) == S1_BASE) w_dec = SEL_S1;
      else if ((WB_SL0_ADR_IN & S2_MASK) == S2_BASE) w_dec = SEL_S2;
      else                                           w_dec = SEL_UNM;
   end

   assign w_dec_oh = {w_dec == SEL_S2, w_dec == SEL_S1, w_dec == SEL_S0};
   assign w_sel_oh = {r_sel == SEL_S2, r_sel == SEL_S1, r_sel == SEL_S0};

   always_comb begin
      case (w_dec)
         SEL_S0:  w_tgt_stall = WB_M0_STALL_IN;
         SEL_S1:  w_tgt_stall = WB_M1_STALL_IN;
         SEL_S2:  w_tgt_stall = WB_M2_STALL_IN;
         default: w_tgt_stall = 1'b0;
      endcase
   end

   // Unmapped beats are answered from r_unm_err, one cycle after acceptance
   always_comb begin
      w_rsp_ack = 1'b0;
      w_rsp_err = 1'b0;
      w_rsp_dat = '0;
      case (r_sel)
         SEL_S0: begin
            w_rsp_ack = WB_M0_ACK_IN;
            w_rsp_err = WB_M0_ERR_IN;
            w_rsp_dat = WB_M0_RD_DAT_IN;
         end
         SEL_S1: begin
            w_rsp_ack = WB_M1_ACK_IN;
            w_rsp_err = WB_M1_ERR_IN;
            w_rsp_dat = WB_M1_RD_DAT_IN;
         end
         SEL_S2: begin
            w_rsp_ack = WB_M2_ACK_IN;
            w_rsp_err = WB_M2_ERR_IN;
            w_rsp_dat = WB_M2_RD_DAT_IN;
         end
         SEL_UNM: w_rsp_err = r_unm_err;
         default: begin
         end
      endcase
   end

   assign w_busy  = (r_cnt != 4'd0);
   assign w_full  = (r_cnt == c_MAX_OUTST);
   assign w_drain = w_busy & (w_dec != r_sel);
   assign w_stall = w_drain | w_full | w_tgt_stall;
   assign w_live  = RST_ASYNC_N & WB_SL0_CYC_IN;
   assign w_acc   = w_live & WB_SL0_STB_IN & ~w_stall;
   assign w_ack   = w_live & w_busy & w_rsp_ack;
   assign w_err   = w_live & w_busy & (w_rsp_err | w_tmo_hit);
   assign w_rsp   = w_ack | w_err;

`ifdef WB_DEC_TIMEOUT_EN
   localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

   logic [7:0] r_tmo;
   logic       w_progress;

   // Fires on the cycle the counter would reach TIMEOUT, so ERR lands TIMEOUT cycles after the last progress
   assign w_progress = w_acc | (w_busy & (w_rsp_ack | w_rsp_err));
   assign w_tmo_hit  = w_busy & WB_SL0_CYC_IN & ~w_progress & (r_tmo == c_TMO_LAST);

   always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
      if (!RST_ASYNC_N) begin
         r_tmo <= '0;
      end else if (!w_busy || !WB_SL0_CYC_IN || w_progress || w_tmo_hit) begin
         r_tmo <= '0;
      end else begin
         r_tmo <= r_tmo + 8'd1;
      end
   end
`else
   logic [7:0] w_unused_tmo;
   assign w_unused_tmo = 8'(TIMEOUT);
   assign w_tmo_hit    = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
      if (!RST_ASYNC_N) begin
         r_cnt     <= 4'd0;
         r_sel     <= SEL_NONE;
         r_unm_err <= 1'b0;
      end else if (!WB_SL0_CYC_IN || w_tmo_hit) begin
         r_cnt     <= 4'd0;
         r_sel     <= SEL_NONE;
         r_unm_err <= 1'b0;
      end else begin
         r_unm_err <= w_acc & (w_dec == SEL_UNM);
         if (w_acc && !w_rsp)      r_cnt <= r_cnt + 4'd1;
         else if (!w_acc && w_rsp) r_cnt <= r_cnt - 4'd1;
         if (w_acc)                          r_sel <= w_dec;
         else if (w_rsp && r_cnt == 4'd1)    r_sel <= SEL_NONE;
      end
   end

   assign WB_SL0_STALL_OUT  = ~RST_ASYNC_N | w_stall;
   assign WB_SL0_ACK_OUT    = w_ack;
   assign WB_SL0_ERR_OUT    = w_err;
   assign WB_SL0_RD_DAT_OUT = (w_live & w_busy) ? w_rsp_dat : 32'h0;

   logic       w_stb_ok;
   logic [2:0] w_stb_oh, w_cyc_oh;

   assign w_stb_ok = w_live & WB_SL0_STB_IN & ~w_drain & ~w_full & ~w_tmo_hit;
   assign w_stb_oh = {3{w_stb_ok}} & w_dec_oh;
   assign w_cyc_oh = {3{w_live & ~w_tmo_hit}} & (w_sel_oh | (w_dec_oh & {3{WB_SL0_STB_IN}}));

   assign WB_M0_CYC_OUT = w_cyc_oh[0];
   assign WB_M1_CYC_OUT = w_cyc_oh[1];
   assign WB_M2_CYC_OUT = w_cyc_oh[2];
   assign WB_M0_STB_OUT = w_stb_oh[0];
   assign WB_M1_STB_OUT = w_stb_oh[1];
   assign WB_M2_STB_OUT = w_stb_oh[2];

   assign WB_M0_ADR_OUT    = WB_SL0_ADR_IN;
   assign WB_M0_WE_OUT     = WB_SL0_WE_IN;
   assign WB_M0_SEL_OUT    = WB_SL0_SEL_IN;
   assign WB_M0_CTI_OUT    = WB_SL0_CTI_IN;
   assign WB_M0_BTE_OUT    = WB_SL0_BTE_IN;
   assign WB_M0_WR_DAT_OUT = WB_SL0_WR_DAT_IN;
   assign WB_M1_ADR_OUT    = WB_SL0_ADR_IN;
   assign WB_M1_WE_OUT     = WB_SL0_WE_IN;
   assign WB_M1_SEL_OUT    = WB_SL0_SEL_IN;
   assign WB_M1_CTI_OUT    = WB_SL0_CTI_IN;
   assign WB_M1_BTE_OUT    = WB_SL0_BTE_IN;
   assign WB_M1_WR_DAT_OUT = WB_SL0_WR_DAT_IN;
   assign WB_M2_ADR_OUT    = WB_SL0_ADR_IN;
   assign WB_M2_WE_OUT     = WB_SL0_WE_IN;
   assign WB_M2_SEL_OUT    = WB_SL0_SEL_IN;
   assign WB_M2_CTI_OUT    = WB_SL0_CTI_IN;
   assign WB_M2_BTE_OUT    = WB_SL0_BTE_IN;
   assign WB_M2_WR_DAT_OUT = WB_SL0_WR_DAT_IN;

endmodule
`default_nettype wire

// File: tb/tb_wb_dec_1m_3s.sv
`default_nettype none
// =============================================================================
// tb_wb_dec_1m_3s : vector table, directed corner sequences and random traffic
//                   checked against a queue-based model of the decoder.
// Revision        : 1.0 - initial release
// =============================================================================
module tb_wb_dec_1m_3s;

   localparam int MAXO = 4;

   logic        CLK = 1'b0;
   logic        RST_ASYNC_N;
   logic [31:0] adr, wdat;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        stall_o, ack_o, err_o;
   logic [31:0] rdat_o;
   logic [2:0]  s_stall, s_ack, s_err, m_cyc, m_stb, m_we;
   logic [31:0] s_dat [3];
   logic [31:0] m_adr [3];
   logic [31:0] m_wdat [3];
   logic [3:0]  m_sel [3];
   logic [2:0]  m_cti [3];
   logic [1:0]  m_bte [3];

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   wb_dec_1m_3s #(.MAX_OUTST(MAXO), .TIMEOUT(16)) dut (
      .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N),
      .WB_SL0_ADR_IN(adr), .WB_SL0_CYC_IN(cyc), .WB_SL0_STB_IN(stb), .WB_SL0_WE_IN(we),
      .WB_SL0_SEL_IN(sel), .WB_SL0_CTI_IN(cti), .WB_SL0_BTE_IN(bte), .WB_SL0_WR_DAT_IN(wdat),
      .WB_SL0_STALL_OUT(stall_o), .WB_SL0_ACK_OUT(ack_o), .WB_SL0_ERR_OUT(err_o),
      .WB_SL0_RD_DAT_OUT(rdat_o),
      .WB_M0_ADR_OUT(m_adr[0]), .WB_M0_WE_OUT(m_we[0]), .WB_M0_SEL_OUT(m_sel[0]),
      .WB_M0_CTI_OUT(m_cti[0]), .WB_M0_BTE_OUT(m_bte[0]), .WB_M0_WR_DAT_OUT(m_wdat[0]),
      .WB_M0_CYC_OUT(m_cyc[0]), .WB_M0_STB_OUT(m_stb[0]), .WB_M0_STALL_IN(s_stall[0]),
      .WB_M0_ACK_IN(s_ack[0]), .WB_M0_ERR_IN(s_err[0]), .WB_M0_RD_DAT_IN(s_dat[0]),
      .WB_M1_ADR_OUT(m_adr[1]), .WB_M1_WE_OUT(m_we[1]), .WB_M1_SEL_OUT(m_sel[1]),
      .WB_M1_CTI_OUT(m_cti[1]), .WB_M1_BTE_OUT(m_bte[1]), .WB_M1_WR_DAT_OUT(m_wdat[1]),
      .WB_M1_CYC_OUT(m_cyc[1]), .WB_M1_STB_OUT(m_stb[1]), .WB_M1_STALL_IN(s_stall[1]),
      .WB_M1_ACK_IN(s_ack[1]), .WB_M1_ERR_IN(s_err[1]), .WB_M1_RD_DAT_IN(s_dat[1]),
      .WB_M2_ADR_OUT(m_adr[2]), .WB_M2_WE_OUT(m_we[2]), .WB_M2_SEL_OUT(m_sel[2]),
      .WB_M2_CTI_OUT(m_cti[2]), .WB_M2_BTE_OUT(m_bte[2]), .WB_M2_WR_DAT_OUT(m_wdat[2]),
      .WB_M2_CYC_OUT(m_cyc[2]), .WB_M2_STB_OUT(m_stb[2]), .WB_M2_STALL_IN(s_stall[2]),
      .WB_M2_ACK_IN(s_ack[2]), .WB_M2_ERR_IN(s_err[2]), .WB_M2_RD_DAT_IN(s_dat[2])
   );

   // Model: queue of accepted-but-unanswered beats, each tagged with its target and due cycle
   typedef struct {
      int tgt;
      int due;
   } beat_t;

   beat_t q[$];
   int    now      = 0;
   bit    model_on = 1'b1;

   function automatic int dec_f(input logic [31:0] a);
      int r;
      case (a[31:28])
         4'h0:    r = 0;
         4'h1:    r = 1;
         4'h2:    r = 2;
         default: r = 3;
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_vec(output logic [40:0] e, output bit acc, output bit rsp);
      int          d, s;
      bit          busy, drain, st, a, er;
      logic [31:0] dat;
      logic [2:0]  es, ec;
      d = dec_f(adr);
      busy = (q.size() > 0);
      s = busy ? q[0].tgt : -1;
      drain = busy && (d != s);
      st = drain || (q.size() >= MAXO) || (d < 3 && s_stall[d] == 1'b1);
      es = 3'b000;
      ec = 3'b000;
      for (int n = 0; n < 3; n++) begin
         es[n] = stb && cyc && (d == n) && !drain && (q.size() < MAXO);
         ec[n] = cyc && ((s == n) || ((d == n) && stb));
      end
      a = 1'b0;
      er = 1'b0;
      dat = 32'h0;
      if (cyc && busy) begin
         if (s < 3) begin
            a = s_ack[s];
            er = s_err[s];
            dat = s_dat[s];
         end else begin
            er = (q[0].due == now);
         end
      end
      acc = stb && cyc && !st;
      rsp = a || er;
      if (!RST_ASYNC_N) begin
         e = {1'b1, 40'b0};
         acc = 1'b0;
         rsp = 1'b0;
      end else begin
         e = {st, a, er, dat, es, ec};
      end
   endtask

   // One clock: settle, compare all outputs with the model, cross the edge, advance the model
   task automatic cycle(input string tag);
      logic [40:0] e, act;
      bit          acc, rsp;
      int          d;
      #1;
      expect_vec(e, acc, rsp);
      act = {stall_o, ack_o, err_o, rdat_o, m_stb, m_cyc};
      if (model_on) begin
         chk({tag, "_outs"}, 80'(act), 80'(e));
         for (int n = 0; n < 3; n++)
            chk($sformatf("%s_bcast%0d", tag, n),
                {6'b0, m_we[n], m_sel[n], m_cti[n], m_bte[n], m_adr[n], m_wdat[n]},
                {6'b0, we, sel, cti, bte, adr, wdat});
      end
      d = dec_f(adr);
      @(posedge CLK);
      if (!RST_ASYNC_N || !cyc) begin
         q.delete();
      end else begin
         if (rsp) void'(q.pop_front());
         if (acc) q.push_back('{d, now + 1});
      end
      now++;
      #1;
   endtask

   task automatic drive(input logic c, input logic s, input logic [31:0] a);
      cyc  = c;
      stb  = s;
      adr  = a;
      we   = 1'($urandom);
      sel  = 4'($urandom);
      cti  = 3'($urandom);
      bte  = 2'($urandom);
      wdat = $urandom;
   endtask

   task automatic idle(input string tag);
      drive(1'b0, 1'b0, 32'h0);
      s_ack   = 3'b000;
      s_err   = 3'b000;
      s_stall = 3'b000;
      cycle(tag);
   endtask

   typedef struct {
      logic [31:0] adr;
      logic        stb;
      logic [2:0]  sstall;
      logic [2:0]  e_stb;
      logic [2:0]  e_cyc;
      logic        e_stall;
   } vec_t;

   vec_t tbl [8];
   int   acks, lat;

   initial begin
      tbl[0] = '{32'h0000_1234, 1'b1, 3'b000, 3'b001, 3'b001, 1'b0};
      tbl[1] = '{32'h1FFF_FFFC, 1'b1, 3'b000, 3'b010, 3'b010, 1'b0};
      tbl[2] = '{32'h2000_0000, 1'b1, 3'b000, 3'b100, 3'b100, 1'b0};
      tbl[3] = '{32'h3000_0000, 1'b1, 3'b111, 3'b000, 3'b000, 1'b0};
      tbl[4] = '{32'h0000_0000, 1'b1, 3'b001, 3'b001, 3'b001, 1'b1};
      tbl[5] = '{32'h1000_0000, 1'b1, 3'b101, 3'b010, 3'b010, 1'b0};
      tbl[6] = '{32'h2000_0004, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[7] = '{32'hFFFF_FFFF, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0};

      // Reset: forced outputs regardless of master/slave activity
      RST_ASYNC_N = 1'b0;
      drive(1'b1, 1'b1, 32'h1000_0000);
      s_stall = 3'b000; s_ack = 3'b111; s_err = 3'b111;
      for (int n = 0; n < 3; n++) s_dat[n] = 32'hA5A5_0000 + 32'(n);
      #1;
      chk("rst_stall", 80'(stall_o), 80'(1'b1));
      chk("rst_cyc_stb", 80'({m_cyc, m_stb}), 80'(6'b0));
      chk("rst_rsp", 80'({ack_o, err_o, rdat_o}), 80'(34'h0));
      cycle("rst0");
      cycle("rst1");
      RST_ASYNC_N = 1'b1;
      idle("rel");

      // Decode / routing table from the idle state
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, tbl[i].stb, tbl[i].adr);
         s_stall = tbl[i].sstall;
         #1;
         chk($sformatf("tbl%0d_stb", i), 80'(m_stb), 80'(tbl[i].e_stb));
         chk($sformatf("tbl%0d_cyc", i), 80'(m_cyc), 80'(tbl[i].e_cyc));
         chk($sformatf("tbl%0d_stall", i), 80'(stall_o), 80'(tbl[i].e_stall));
         cycle("tbl");
         idle("tbl_idle");
      end

      // Single read to slave 1
      drive(1'b1, 1'b1, 32'h1000_0040); we = 1'b0;
      #1;
      chk("rd_stb", 80'(m_stb), 80'(3'b010));
      chk("rd_stall", 80'(stall_o), 80'(1'b0));
      cycle("rd0");
      drive(1'b1, 1'b0, 32'h1000_0040);
      s_ack = 3'b010; s_dat[1] = 32'hCAFE_F00D;
      #1;
      chk("rd_ack", 80'(ack_o), 80'(1'b1));
      chk("rd_dat", 80'(rdat_o), 80'(32'hCAFE_F00D));
      chk("rd_stb_low", 80'(m_stb), 80'(3'b000));
      cycle("rd1");
      s_ack = 3'b000;
      #1;
      chk("rd_done_cyc", 80'(m_cyc), 80'(3'b000));
      chk("rd_done_ack", 80'(ack_o), 80'(1'b0));
      cycle("rd2");
      idle("rd_idle");

      // Four pipelined writes to slave 0; fifth beat must stall at MAX_OUTST
      acks = 0;
      for (int c = 0; c < 9; c++) begin
         drive(1'b1, c <= 4, 32'h0000_0100 + 32'(4 * c));
         we = 1'b1;
         s_ack = (c >= 4 && c <= 7) ? 3'b001 : 3'b000;
         #1;
         if (c == 4) begin
            chk("wr_full_stall", 80'(stall_o), 80'(1'b1));
            chk("wr_full_stb", 80'(m_stb), 80'(3'b000));
         end
         chk($sformatf("wr_ack%0d", c), 80'(ack_o), 80'(c >= 4 && c <= 7));
         chk($sformatf("wr_other%0d", c), 80'(m_stb[2:1]), 80'(2'b00));
         if (ack_o) acks++;
         cycle("wr");
      end
      chk("wr_ack_count", 80'(acks), 80'(4));
      idle("wr_idle");

      // Change of target waits for the outstanding slave-0 beat to drain
      drive(1'b1, 1'b1, 32'h0000_0010);
      cycle("dr0");
      for (int c = 1; c <= 3; c++) begin
         drive(1'b1, 1'b1, 32'h2000_0000);
         s_ack = (c == 3) ? 3'b001 : 3'b000;
         #1;
         chk($sformatf("dr_stall%0d", c), 80'(stall_o), 80'(1'b1));
         chk($sformatf("dr_stb%0d", c), 80'(m_stb), 80'(3'b000));
         cycle("dr");
      end
      s_ack = 3'b000;
      #1;
      chk("dr_m2_stb", 80'(m_stb), 80'(3'b100));
      chk("dr_m2_stall", 80'(stall_o), 80'(1'b0));
      cycle("dr4");
      drive(1'b1, 1'b0, 32'h2000_0000); s_ack = 3'b100;
      cycle("dr5");
      idle("dr_idle");

      // Two back-to-back unmapped beats
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, c < 2, 32'h8000_0000 + 32'(4 * c));
         #1;
         chk($sformatf("unm_err%0d", c), 80'(err_o), 80'(c == 1 || c == 2));
         chk($sformatf("unm_stb%0d", c), 80'(m_stb), 80'(3'b000));
         chk($sformatf("unm_stall%0d", c), 80'(stall_o), 80'(1'b0));
         cycle("unm");
      end
      idle("unm_idle");

      // Reset with two beats outstanding, late ACK discarded after release
      drive(1'b1, 1'b1, 32'h1000_0000); cycle("rm0");
      drive(1'b1, 1'b1, 32'h1000_0004); cycle("rm1");
      drive(1'b1, 1'b0, 32'h1000_0004);
      RST_ASYNC_N = 1'b0;
      #1;
      chk("rm_stall", 80'(stall_o), 80'(1'b1));
      chk("rm_cyc", 80'(m_cyc), 80'(3'b000));
      cycle("rm2");
      cycle("rm3");
      RST_ASYNC_N = 1'b1;
      s_ack = 3'b010;
      #1;
      chk("rm_late_ack", 80'(ack_o), 80'(1'b0));
      cycle("rm4");
      drive(1'b1, 1'b1, 32'h1000_0020); s_ack = 3'b000;
      #1;
      chk("rm_new_stb", 80'(m_stb), 80'(3'b010));
      chk("rm_new_stall", 80'(stall_o), 80'(1'b0));
      cycle("rm5");
      drive(1'b1, 1'b0, 32'h1000_0020); s_ack = 3'b010;
      #1;
      chk("rm_new_ack", 80'(ack_o), 80'(1'b1));
      cycle("rm6");
      idle("rm_idle");

      // Master abandons the cycle; later and spurious responses are ignored
      drive(1'b1, 1'b1, 32'h2000_0008); cycle("ab0");
      drive(1'b0, 1'b0, 32'h2000_0008); cycle("ab1");
      drive(1'b1, 1'b0, 32'h2000_0008); s_ack = 3'b111; s_err = 3'b111;
      #1;
      chk("ab_late_rsp", 80'({ack_o, err_o}), 80'(2'b00));
      chk("ab_cyc", 80'(m_cyc), 80'(3'b000));
      cycle("ab2");
      idle("ab_idle");

`ifdef WB_DEC_TIMEOUT_EN
      // Silent slave 2: forced ERR TIMEOUT (16) cycles after the accept
      model_on = 1'b0;
      drive(1'b1, 1'b1, 32'h2000_0000);
      cycle("to0");
      drive(1'b1, 1'b0, 32'h2000_0000);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         #1;
         if (err_o && lat < 0) lat = k;
         cycle("to");
      end
      chk("tmo_latency", 80'(lat), 80'(16));
      chk("tmo_cleared", 80'(m_cyc), 80'(3'b000));
      RST_ASYNC_N = 1'b0;
      cycle("to_rst");
      RST_ASYNC_N = 1'b1;
      model_on = 1'b1;
      idle("to_idle");
`endif

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int pick;
         pick = int'($urandom_range(0, 3));
         drive($urandom_range(0, 19) != 0, 1'($urandom),
               {(pick == 3) ? 4'($urandom_range(3, 15)) : 4'(pick), 28'($urandom)});
         for (int n = 0; n < 3; n++) begin
            s_stall[n] = ($urandom_range(0, 3) == 0);
            s_ack[n]   = ($urandom_range(0, 2) == 0);
            s_err[n]   = ($urandom_range(0, 15) == 0);
            s_dat[n]   = $urandom;
         end
         cycle("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
